// File: rtl/secded_search_decoder.sv
// SECDED Hamming decoder that locates a single-bit error by a cycle-per-position search.
// Optional macro SECDED_ERR_CNT_EN adds saturating corrected/uncorrectable error counters.
module secded_search_decoder #(
  parameter int DATA_W = 28,
  parameter int PAR_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W+PAR_W:0]    W,
  output logic                     found,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        N,
  output logic                     err_corr,
  output logic                     err_unc,
  output logic [PAR_W-1:0]         err_pos,
  output logic [15:0]              corr_cnt,
  output logic [15:0]              unc_cnt,
  output logic [1:0]               dbg_state_o
);

  localparam int CW = DATA_W + PAR_W + 1;
  localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CW - 1);

  // Handshakes: a word moves on in_valid && in_ready; a result moves on found && out_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, SYND = 2'd1, SEARCH = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       w_q, w_d;
  logic [PAR_W-1:0]    syn_q, syn_d;
  logic [PAR_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   n_q, n_d;
  logic                corr_q, corr_d;
  logic                unc_q, unc_d;
  logic [PAR_W-1:0]    pos_q, pos_d;

  logic [PAR_W-1:0]    syn_c;
  logic                par_c;
  logic [CW-1:0]       flip_mask;
  logic [CW-1:0]       fixed_w;
  logic [DATA_W-1:0]   n_ext;

  // Data bits sit at the non-power-of-two positions, lowest position first.
  function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] cw);
    int k;
    extract = '0;
    k = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k < DATA_W) extract[k] = cw[p];
        k++;
      end
    end
  endfunction

  always_comb begin
    syn_c = '0;
    for (int p = 1; p < CW; p++) begin
      if (w_q[p]) syn_c = syn_c ^ PAR_W'(p);
    end
    par_c = ^w_q;
  end

  assign flip_mask = CW'(1) << syn_q;
  assign fixed_w   = (state_q == SEARCH) ? (w_q ^ flip_mask) : w_q;
  assign n_ext     = extract(fixed_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      syn_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      corr_q  <= 1'b0;
      unc_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      syn_q   <= syn_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    syn_d   = syn_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    corr_d  = corr_q;
    unc_d   = unc_q;
    pos_d   = pos_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_d     = W;
          cnt_d   = '0;
          corr_d  = 1'b0;
          unc_d   = 1'b0;
          pos_d   = '0;
          state_d = SYND;
        end
      end
      SYND: begin
        syn_d = syn_c;
        n_d   = n_ext;
        if (syn_c == '0) begin
          // Zero syndrome with odd parity means only the overall parity bit flipped.
          corr_d  = par_c;
          state_d = DONE;
        end else if (!par_c || (syn_c > MAX_POS)) begin
          unc_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = PAR_W'(1);
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (cnt_q == syn_q) begin
          w_d     = fixed_w;
          n_d     = n_ext;
          corr_d  = 1'b1;
          pos_d   = syn_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + PAR_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign found       = (state_q == DONE);
  assign N           = n_q;
  assign err_corr    = corr_q;
  assign err_unc     = unc_q;
  assign err_pos     = pos_q;
  assign dbg_state_o = state_q;

`ifdef SECDED_ERR_CNT_EN
  logic [15:0] corr_cnt_q, corr_cnt_d;
  logic [15:0] unc_cnt_q, unc_cnt_d;
  logic        result_hs;

  assign result_hs = (state_q == DONE) && out_ready;

  always_comb begin
    corr_cnt_d = corr_cnt_q;
    unc_cnt_d  = unc_cnt_q;
    if (result_hs && corr_q && (corr_cnt_q != 16'hFFFF)) corr_cnt_d = corr_cnt_q + 16'd1;
    if (result_hs && unc_q && (unc_cnt_q != 16'hFFFF))   unc_cnt_d  = unc_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      unc_cnt_q  <= unc_cnt_d;
    end
  end

  assign corr_cnt = corr_cnt_q;
  assign unc_cnt  = unc_cnt_q;
`else
  assign corr_cnt = 16'd0;
  assign unc_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_secded_search_decoder.sv
// Scoreboard bench for secded_search_decoder: directed codewords with hand-derived results.
module tb_secded_search_decoder;

  localparam int DATA_W = 28;
  localparam int PAR_W  = 6;
  localparam int CW     = 35;
  localparam int EW     = 45;
  // All-ones payload encoded: check bits 1,2,32 are 0, bits 4,8,16 and overall parity are 1.
  localparam logic [CW-1:0] CW_ONES = 35'h6_FFFF_FFF9;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     w;
  logic              found;
  logic              out_ready;
  logic [DATA_W-1:0] n;
  logic              err_corr;
  logic              err_unc;
  logic [PAR_W-1:0]  err_pos;
  logic [15:0]       corr_cnt;
  logic [15:0]       unc_cnt;
  logic [1:0]        dbg_state;

  // Expected entry: {chk_n[44], lat[43:36], pos[35:30], unc[29], corr[28], n[27:0]}
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            exp_corr_cnt = 0;
  int            exp_unc_cnt = 0;

  secded_search_decoder #(.DATA_W(DATA_W), .PAR_W(PAR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .W(w),
    .found(found), .out_ready(out_ready), .N(n), .err_corr(err_corr),
    .err_unc(err_unc), .err_pos(err_pos), .corr_cnt(corr_cnt), .unc_cnt(unc_cnt),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: records acceptances, compares at each result handshake.
  initial begin : monitor
    int first_cyc;
    int a;
    bit have_first;
    bit saw_search;
    logic [EW-1:0] e;
    have_first = 1'b0;
    saw_search = 1'b0;
    first_cyc  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_q.delete();
        have_first = 1'b0;
        saw_search = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          acc_q.push_back(cyc + 1);
          saw_search = 1'b0;
        end
        if (dbg_state == 2'd2) saw_search = 1'b1;
        if (found && !have_first) begin
          have_first = 1'b1;
          first_cyc  = cyc;
        end
        if (found && out_ready) begin
          have_first = 1'b0;
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got N=%0h with no expected entry", n);
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("latency", 64'(first_cyc - a), 64'(e[43:36]));
            if (e[44]) check("N", 64'(n), 64'(e[27:0]));
            check("err_corr", 64'(err_corr), 64'(e[28]));
            check("err_unc", 64'(err_unc), 64'(e[29]));
            check("err_pos", 64'(err_pos), 64'(e[35:30]));
            check("search_visited", 64'(saw_search), 64'(e[43:36] > 8'd1));
`ifdef SECDED_ERR_CNT_EN
            if (e[28]) exp_corr_cnt++;
            if (e[29]) exp_unc_cnt++;
`endif
          end
        end
      end
    end
  end

  // Driver: called at posedge+1 with the DUT idle.
  task automatic send(input logic [CW-1:0] word, input logic [DATA_W-1:0] en, input logic corr,
                      input logic unc, input logic [PAR_W-1:0] pos, input logic [7:0] lat,
                      input logic chk_n);
    exp_q.push_back({chk_n, lat, pos, unc, corr, en});
    in_valid = 1'b1;
    w        = word;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_corr_cnt"}, 64'(corr_cnt), 64'(exp_corr_cnt));
    check({tag, "_unc_cnt"}, 64'(unc_cnt), 64'(exp_unc_cnt));
  endtask

  task automatic xact(input logic [CW-1:0] word, input logic [DATA_W-1:0] en, input logic corr,
                      input logic unc, input logic [PAR_W-1:0] pos, input logic [7:0] lat,
                      input logic chk_n);
    send(word, en, corr, unc, pos, lat, chk_n);
    wait_done();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_found", 64'(found), 64'd0);
    check("rst_N", 64'(n), 64'd0);
    check("rst_flags", 64'({err_corr, err_unc, err_pos}), 64'd0);
    check_counts("rst");
    @(posedge clk);
    #1;

    // Clean, single, double, parity-only and data-edge cases
    xact(CW_ONES, 28'hFFFFFFF, 1'b0, 1'b0, 6'd0, 8'd1, 1'b1);
    xact(CW_ONES ^ (35'd1 << 5), 28'hFFFFFFF, 1'b1, 1'b0, 6'd5, 8'd6, 1'b1);
    xact(CW_ONES ^ (35'd1 << 3) ^ (35'd1 << 9), 28'h0, 1'b0, 1'b1, 6'd0, 8'd1, 1'b0);
    check_counts("after_double");
    xact(CW_ONES ^ 35'd1, 28'hFFFFFFF, 1'b1, 1'b0, 6'd0, 8'd1, 1'b1);
    xact(35'h0, 28'h0, 1'b0, 1'b0, 6'd0, 8'd1, 1'b1);
    xact(35'hF, 28'h1, 1'b0, 1'b0, 6'd0, 8'd1, 1'b1);
    xact(35'h7, 28'h1, 1'b1, 1'b0, 6'd3, 8'd4, 1'b1);
    xact(35'h1_0000_0005, 28'h8000000, 1'b1, 1'b0, 6'd34, 8'd35, 1'b1);
    xact(CW_ONES ^ (35'd1 << 32) ^ (35'd1 << 16) ^ (35'd1 << 8), 28'h0, 1'b0, 1'b1, 6'd0, 8'd1, 1'b0);
    xact(CW_ONES ^ (35'd1 << 1), 28'hFFFFFFF, 1'b1, 1'b0, 6'd1, 8'd2, 1'b1);
    check_counts("after_table");

    // Back-pressure: result must hold and new words must be ignored
    out_ready = 1'b0;
    send(CW_ONES ^ (35'd1 << 5), 28'hFFFFFFF, 1'b1, 1'b0, 6'd5, 8'd6, 1'b1);
    k = 0;
    while (!found && k < 50) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      w        = 35'h0;
      @(negedge clk);
      check("hold_found", 64'(found), 64'd1);
      check("hold_N", 64'(n), 64'hFFFFFFF);
      check("hold_flags", 64'({err_corr, err_unc, err_pos}), 64'({1'b1, 1'b0, 6'd5}));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done();
    @(negedge clk);
    check("post_hold_idle", 64'({in_ready, found}), 64'({1'b1, 1'b0}));
    check_counts("after_hold");
    @(posedge clk);
    #1;

    // Reset in the middle of a long search
    in_valid = 1'b1;
    w        = CW_ONES ^ (35'd1 << 34);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 100 && k < 10; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) k++;
    end
    check("search_cycles_seen", 64'(k), 64'd10);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    exp_corr_cnt = 0;
    exp_unc_cnt  = 0;
    @(negedge clk);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    check("mid_rst_found", 64'(found), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_found", 64'(found), 64'd0);
    check("rel_N", 64'(n), 64'd0);
    check("rel_flags", 64'({err_corr, err_unc, err_pos}), 64'd0);
    check_counts("rel");
    @(posedge clk);
    #1;
    xact(CW_ONES, 28'hFFFFFFF, 1'b0, 1'b0, 6'd0, 8'd1, 1'b1);
    check_counts("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/secded_search_decoder.md
SECDED_SEARCH_DECODER -- requirements
Module: secded_search_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 28, meaning payload width in bits.
REQ-002 SHALL have parameter PAR_W, default 6, meaning Hamming check-bit count; legal only when 2^PAR_W >= DATA_W+PAR_W+1.
REQ-003 SHALL have derived localparam CW = DATA_W+PAR_W+1, meaning codeword width (35 at defaults).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, meaning W is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block can accept a codeword.
REQ-008 SHALL have port W, input, CW, meaning received codeword.
REQ-009 SHALL have port found, output, 1, meaning result valid (out-valid).
REQ-010 SHALL have port out_ready, input, 1, meaning consumer accepts the result.
REQ-011 SHALL have port N, output, DATA_W, meaning corrected payload.
REQ-012 SHALL have port err_corr, output, 1, meaning a single error was corrected.
REQ-013 SHALL have port err_unc, output, 1, meaning the error is uncorrectable.
REQ-014 SHALL have port err_pos, output, PAR_W, meaning the corrected position, or 0.
REQ-015 SHALL have ports corr_cnt and unc_cnt, output, 16 each, meaning error statistics (see Configuration).

Function
REQ-016 Code layout SHALL be: W[0] = overall parity; W[p] for p = 1..CW-1 = Hamming position p; check bits at power-of-two positions; data bits at the remaining positions in ascending order, with the lowest position mapping to N[0].
REQ-017 FSM states SHALL be IDLE, SYND, SEARCH and DONE; in_ready SHALL equal (state==IDLE).
REQ-018 IDLE: when in_valid is high, the block SHALL register W and go to SYND on that edge.
REQ-019 SYND SHALL compute syndrome s (XOR of positions with bit set) and overall parity P (XOR of all CW bits) in one cycle:
  - s=0, P=0: go to DONE with no error.
  - s=0, P=1: go to DONE; err_corr=1, err_pos=0, N unchanged.
  - s!=0, P=0: go to DONE with err_unc=1 (double error).
  - s>CW-1, P=1: go to DONE with err_unc=1.
  - Otherwise: go to SEARCH with cnt=1.
REQ-020 SEARCH SHALL increment cnt once per cycle; on the cycle where cnt==s it SHALL flip bit s, set err_corr=1 and err_pos=s, and go to DONE.
REQ-021 Latency from the acceptance edge to found=1 SHALL be 1 edge for non-search cases and 1+s edges for a search.
REQ-022 DONE: found=1; N, err_* and err_pos SHALL hold stable until found && out_ready, which returns the state to IDLE; there is no same-edge re-accept.
REQ-023 When entering SYND, err_corr, err_unc and err_pos SHALL clear; N SHALL be valid only while found=1.

Reset
REQ-024 On rst high, regardless of state (including mid-SEARCH), the block SHALL immediately enter IDLE with found=0, N=0, err_corr=0, err_unc=0, err_pos=0, cnt=0, and counters=0; the in-flight word is discarded.
REQ-025 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-026 With macro SECDED_ERR_CNT_EN defined, corr_cnt and unc_cnt SHALL each increment by 1 on every DONE->IDLE handshake with the matching flag, saturating at 16'hFFFF.
REQ-027 Without SECDED_ERR_CNT_EN, corr_cnt and unc_cnt SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-028 Clean word, payload 28'hFFFFFFF at defaults: found after 1 edge, N=28'hFFFFFFF, err_corr=0, err_unc=0.
REQ-029 Same word with position 5 flipped: found after 6 edges, N=28'hFFFFFFF, err_corr=1, err_pos=5.
REQ-030 Positions 3 and 9 flipped: found after 1 edge, err_unc=1; with SECDED_ERR_CNT_EN, unc_cnt goes 0->1 after the handshake.
REQ-031 Only W[0] flipped: err_corr=1, err_pos=0, N=28'hFFFFFFF, no SEARCH state visited.
REQ-032 Hold out_ready=0 for 10 cycles in DONE: found, N and flags stay stable, in_ready=0, and in_valid is ignored.
REQ-033 Single error at position 34, rst pulsed at the 10th SEARCH cycle: found=0 and in_ready=1 after release; the next clean word decodes correctly.
